// File: rtl/clint_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Shared register map and helpers for the multi-hart CLINT.
//   MSIP_OFS      : base offset of the per-hart MSIP words (4-byte stride)
//   MTIMECMP_OFS  : base offset of the per-hart MTIMECMP pairs (8-byte stride)
//   MTIME_OFS     : offset of MTIME lo (hi lives at +4)
//   MSIP_SW_BIT / MSIP_EX_BIT : bit positions inside an MSIP word
// -----------------------------------------------------------------------------
package clint_pkg;

  localparam logic [15:0] MSIP_OFS     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
  localparam logic [15:0] MTIME_OFS    = 16'hBFF8;

  localparam int MSIP_SW_BIT = 0;
  localparam int MSIP_EX_BIT = 16;

  // Merge new_val into old_val one byte at a time; unstrobed bytes keep old_val.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// -----------------------------------------------------------------------------
// clint_timer
// Prescaler plus free-running 64-bit mtime with byte-strobed load.
//   clk, reset       : clock, synchronous active-high reset
//   i_timer_en       : advance enable; prescaler and mtime hold when low
//   i_ld_lo/i_ld_hi  : load strobes for mtime[31:0] / mtime[63:32]
//   i_wdata/i_wstrb  : load data and byte strobes
//   o_mtime          : current mtime register value
// -----------------------------------------------------------------------------
module clint_timer
  import clint_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_timer_en,
  input  logic        i_ld_lo,
  input  logic        i_ld_hi,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic [63:0] o_mtime
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [63:0]   r_mtime;

  // Software load beats the increment and restarts the prescaler so the next
  // tick lands a full TICK_DIV cycles after the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre   <= '0;
      r_mtime <= '0;
    end else if (i_ld_lo || i_ld_hi) begin
      r_pre <= '0;
      if (i_ld_lo) r_mtime[31:0]  <= apply_strb(r_mtime[31:0],  i_wdata, i_wstrb);
      if (i_ld_hi) r_mtime[63:32] <= apply_strb(r_mtime[63:32], i_wdata, i_wstrb);
    end else if (i_timer_en) begin
      if (r_pre == PRE_LAST) begin
        r_pre   <= '0;
        r_mtime <= r_mtime + 64'd1;  // silently wraps at 2^64-1
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign o_mtime = r_mtime;

endmodule

// File: rtl/clint_mh.sv
// -----------------------------------------------------------------------------
// clint_mh
// Multi-hart core-local interruptor: MSIP, MTIMECMP per hart and shared MTIME.
//   clk, reset                 : clock, synchronous active-high reset
//   timer_en                   : prescaler/mtime advance enable
//   wready/waddr/wdata/wstrb   : write request (always accepted, wvalid=1)
//   rready/raddr               : read request (always accepted, rvalid=1)
//   rresp/rdata                : registered read response, one cycle later
//   timer_irq/sw_irq/ex_irq    : per-hart interrupt lines
// Bus handshake: wvalid and rvalid are constant 1, so a request is taken in
// every cycle its wready/rready is high; read data follows one cycle later,
// flagged by rresp.
// -----------------------------------------------------------------------------
module clint_mh
  import clint_pkg::*;
#(
  parameter int          NHART    = 2,
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             timer_en,
  input  logic             wready,
  output logic             wvalid,
  input  logic [31:0]      waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             rready,
  output logic             rvalid,
  input  logic [31:0]      raddr,
  output logic             rresp,
  output logic [31:0]      rdata,
  output logic [NHART-1:0] timer_irq,
  output logic [NHART-1:0] sw_irq,
  output logic [NHART-1:0] ex_irq
);

  localparam logic [31:0] MTIME_LO = 32'(MTIME_OFS);
  localparam logic [31:0] MTIME_HI = 32'(MTIME_OFS) + 32'd4;

  // Word-aligned offsets from BASE; bits [1:0] are dropped here.
  logic [31:0] w_wa;
  logic [31:0] w_ra;
  assign w_wa = (waddr - BASE) & 32'hFFFF_FFFC;
  assign w_ra = (raddr - BASE) & 32'hFFFF_FFFC;

  assign wvalid = 1'b1;
  assign rvalid = 1'b1;

  logic        w_mt_ld_lo;
  logic        w_mt_ld_hi;
  logic [63:0] w_mtime;

  assign w_mt_ld_lo = wready && (w_wa == MTIME_LO);
  assign w_mt_ld_hi = wready && (w_wa == MTIME_HI);

  clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_timer_en (timer_en),
    .i_ld_lo    (w_mt_ld_lo),
    .i_ld_hi    (w_mt_ld_hi),
    .i_wdata    (wdata),
    .i_wstrb    (wstrb),
    .o_mtime    (w_mtime)
  );

  // Flattened per-hart compare values for the read mux.
  logic [64*NHART-1:0] w_cmp_flat;

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    localparam logic [31:0] MSIP_A   = 32'(MSIP_OFS) + 32'(4 * h);
    localparam logic [31:0] CMP_LO_A = 32'(MTIMECMP_OFS) + 32'(8 * h);
    localparam logic [31:0] CMP_HI_A = CMP_LO_A + 32'd4;

    logic [63:0] r_cmp;
    logic        r_sw;
    logic        r_ex;
    logic        r_tirq;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cmp <= '1;
      end else begin
        if (wready && (w_wa == CMP_LO_A)) r_cmp[31:0]  <= apply_strb(r_cmp[31:0],  wdata, wstrb);
        if (wready && (w_wa == CMP_HI_A)) r_cmp[63:32] <= apply_strb(r_cmp[63:32], wdata, wstrb);
      end
    end

    // Only bit0 (byte 0) and bit16 (byte 2) of an MSIP word are storage.
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sw <= 1'b0;
        r_ex <= 1'b0;
      end else if (wready && (w_wa == MSIP_A)) begin
        if (wstrb[MSIP_SW_BIT / 8]) r_sw <= wdata[MSIP_SW_BIT];
        if (wstrb[MSIP_EX_BIT / 8]) r_ex <= wdata[MSIP_EX_BIT];
      end
    end

    // Compare uses the current register values, so the line lags by a cycle.
    always_ff @(posedge clk) begin
      if (reset) r_tirq <= 1'b0;
      else       r_tirq <= (w_mtime >= r_cmp);
    end

    assign timer_irq[h]           = r_tirq;
    assign sw_irq[h]              = r_sw;
    assign ex_irq[h]              = r_ex;
    assign w_cmp_flat[h*64 +: 64] = r_cmp;
  end

  logic [31:0] w_rdata_nxt;

  always_comb begin
    w_rdata_nxt = '0;
    if (w_ra == MTIME_LO) w_rdata_nxt = w_mtime[31:0];
    if (w_ra == MTIME_HI) w_rdata_nxt = w_mtime[63:32];
    for (int h = 0; h < NHART; h++) begin
      if (w_ra == 32'(MSIP_OFS) + 32'(4 * h))
        w_rdata_nxt = {15'h0, ex_irq[h], 15'h0, sw_irq[h]};
      if (w_ra == 32'(MTIMECMP_OFS) + 32'(8 * h))
        w_rdata_nxt = w_cmp_flat[h*64 +: 32];
      if (w_ra == 32'(MTIMECMP_OFS) + 32'(8 * h) + 32'd4)
        w_rdata_nxt = w_cmp_flat[h*64 + 32 +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rresp <= 1'b0;
    else       rresp <= rready;
  end

  // Read data is intentionally not reset; rresp qualifies it.
  always_ff @(posedge clk) begin
    if (rready) rdata <= w_rdata_nxt;
  end

endmodule

// File: tb/tb_clint_mh.sv
// -----------------------------------------------------------------------------
// tb_clint_mh
// Directed bench for clint_mh with NHART=2, TICK_DIV=4.
// -----------------------------------------------------------------------------
module tb_clint_mh;

  localparam int          NHART    = 2;
  localparam logic [31:0] BASE     = 32'h0200_0000;
  localparam int          TICK_DIV = 4;

  localparam logic [31:0] MT_LO   = BASE + 32'hBFF8;
  localparam logic [31:0] MT_HI   = BASE + 32'hBFFC;
  localparam logic [31:0] CMP0_LO = BASE + 32'h4000;
  localparam logic [31:0] CMP0_HI = BASE + 32'h4004;
  localparam logic [31:0] CMP1_LO = BASE + 32'h4008;
  localparam logic [31:0] CMP1_HI = BASE + 32'h400C;
  localparam logic [31:0] MSIP0   = BASE + 32'h0000;
  localparam logic [31:0] MSIP1   = BASE + 32'h0004;

  logic             clk;
  logic             reset;
  logic             timer_en;
  logic             wready;
  logic             wvalid;
  logic [31:0]      waddr;
  logic [31:0]      wdata;
  logic [3:0]       wstrb;
  logic             rready;
  logic             rvalid;
  logic [31:0]      raddr;
  logic             rresp;
  logic [31:0]      rdata;
  logic [NHART-1:0] timer_irq;
  logic [NHART-1:0] sw_irq;
  logic [NHART-1:0] ex_irq;

  int checks = 0;
  int errors = 0;

  clint_mh #(
    .NHART    (NHART),
    .BASE     (BASE),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .timer_en  (timer_en),
    .wready    (wready),
    .wvalid    (wvalid),
    .waddr     (waddr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rready    (rready),
    .rvalid    (rvalid),
    .raddr     (raddr),
    .rresp     (rresp),
    .rdata     (rdata),
    .timer_irq (timer_irq),
    .sw_irq    (sw_irq),
    .ex_irq    (ex_irq)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr  = a;
    wdata  = d;
    wstrb  = s;
    wready = 1'b1;
    step(1);
    wready = 1'b0;
    wstrb  = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    raddr  = a;
    rready = 1'b1;
    step(1);
    rready = 1'b0;
    d      = rdata;
    check("rresp", {31'h0, rresp}, 32'h1);
  endtask

  logic [31:0] rd;

  initial begin
    reset    = 1'b1;
    timer_en = 1'b1;
    wready   = 1'b0;
    waddr    = '0;
    wdata    = '0;
    wstrb    = '0;
    rready   = 1'b0;
    raddr    = '0;

    // reset state
    step(3);
    check("rst_timer_irq", {30'h0, timer_irq}, 32'h0);
    check("rst_sw_irq",    {30'h0, sw_irq},    32'h0);
    check("rst_ex_irq",    {30'h0, ex_irq},    32'h0);
    check("rst_rresp",     {31'h0, rresp},     32'h0);
    check("wvalid",        {31'h0, wvalid},    32'h1);
    check("rvalid",        {31'h0, rvalid},    32'h1);

    // 40 cycles at TICK_DIV=4 -> mtime 10
    reset = 1'b0;
    step(40);
    bus_read(MT_LO, rd);
    check("mtime_after_40", rd, 32'd10);
    check("irq_after_40", {30'h0, timer_irq}, 32'h0);
    bus_read(CMP0_HI, rd);
    check("cmp0_hi_reset", rd, 32'hFFFF_FFFF);
    step(1);
    check("rresp_drop", {31'h0, rresp}, 32'h0);
    timer_en = 1'b0;

    // MTIMECMP[1]=20, mtime 19 -> 20, irq one cycle later
    bus_write(MT_HI, 32'h0, 4'hF);
    bus_write(CMP1_LO, 32'd20, 4'hF);
    bus_write(CMP1_HI, 32'd0, 4'hF);
    bus_write(MT_LO, 32'd19, 4'hF);
    timer_en = 1'b1;
    step(4);
    check("irq_at_mtime20", {30'h0, timer_irq}, 32'h0);
    step(1);
    check("irq_after_mtime20", {30'h0, timer_irq}, 32'h2);
    timer_en = 1'b0;

    // 64-bit unsigned compare
    bus_write(CMP0_LO, 32'h0, 4'hF);
    bus_write(CMP0_HI, 32'h1, 4'hF);
    step(1);
    check("cmp64_below", {30'h0, timer_irq}, 32'h2);
    bus_write(MT_HI, 32'h1, 4'hF);
    step(1);
    check("cmp64_above", {30'h0, timer_irq}, 32'h3);

    // byte strobes on MTIME lo
    bus_write(MT_LO, 32'h0, 4'hF);
    bus_write(MT_LO, 32'hFFFF_FFFF, 4'b0011);
    bus_read(MT_LO, rd);
    check("mtime_strb", rd, 32'h0000_FFFF);

    // MTIME write coinciding with a prescaler wrap
    bus_write(MT_LO, 32'h0, 4'hF);
    timer_en = 1'b1;
    step(3);
    bus_write(MT_LO, 32'd5, 4'hF);
    bus_read(MT_LO, rd);
    check("ld_over_wrap", rd, 32'd5);
    step(2);
    bus_read(MT_LO, rd);
    check("hold_before_tick", rd, 32'd5);
    bus_read(MT_LO, rd);
    check("tick_after_div", rd, 32'd6);
    timer_en = 1'b0;

    // simultaneous read and write of the same address
    waddr  = MT_LO;
    wdata  = 32'd77;
    wstrb  = 4'hF;
    wready = 1'b1;
    raddr  = MT_LO;
    rready = 1'b1;
    step(1);
    wready = 1'b0;
    rready = 1'b0;
    check("rw_same_old", rdata, 32'd6);
    bus_read(MT_LO, rd);
    check("rw_same_new", rd, 32'd77);

    // MSIP
    bus_write(MSIP1, 32'h0001_0001, 4'hF);
    check("msip1_sw", {30'h0, sw_irq}, 32'h2);
    check("msip1_ex", {30'h0, ex_irq}, 32'h2);
    bus_read(MSIP1, rd);
    check("msip1_read", rd, 32'h0001_0001);
    bus_write(MSIP0, 32'hFFFF_FFFF, 4'b0001);
    check("msip0_sw_strb", {30'h0, sw_irq}, 32'h3);
    check("msip0_ex_strb", {30'h0, ex_irq}, 32'h2);
    bus_read(MSIP0, rd);
    check("msip0_read", rd, 32'h0000_0001);

    // out-of-range hart / unmapped
    bus_write(BASE + 32'h4010, 32'hDEAD, 4'hF);
    bus_read(BASE + 32'h4010, rd);
    check("hart2_cmp_read", rd, 32'h0);
    bus_read(CMP1_LO, rd);
    check("cmp1_untouched", rd, 32'd20);
    check("sw_untouched", {30'h0, sw_irq}, 32'h3);
    bus_read(BASE + 32'h4006, rd);
    check("unaligned_cmp0_hi", rd, 32'h1);
    bus_read(BASE + 32'h8000, rd);
    check("unmapped_read", rd, 32'h0);

    // reset mid-count
    timer_en = 1'b1;
    step(7);
    check("irq_before_reset", {30'h0, timer_irq}, 32'h3);
    reset = 1'b1;
    step(1);
    reset    = 1'b0;
    timer_en = 1'b0;
    check("reset_timer_irq", {30'h0, timer_irq}, 32'h0);
    check("reset_sw_irq",    {30'h0, sw_irq},    32'h0);
    check("reset_ex_irq",    {30'h0, ex_irq},    32'h0);
    bus_read(MT_LO, rd);
    check("reset_mtime", rd, 32'h0);
    bus_read(CMP0_LO, rd);
    check("reset_cmp0_lo", rd, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
